muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port start  input  1  EX stage holds a mult/div instruction; level, held until valid.
REQ-004 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports a, b  input  32 each  rs and rt operands; a is the dividend, b is the divisor.
REQ-006 SHALL have port flush  input  1  pipeline flush/exception; cancels the operation in flight.
REQ-007 SHALL have port stall  output  1  freeze pipeline front-end.
REQ-008 SHALL have port valid  output  1  one-cycle pulse; hi/lo hold the final result.
REQ-009 SHALL have ports hi, lo  output  32 each  result: product {hi,lo}; for divides hi = remainder, lo = quotient.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-011 SHALL accept in IDLE when start=1 and flush=0, latching a, b, op and zeroing the iteration counter at that edge (E0).
REQ-012 SHALL, for op=MULT/MULTU, go IDLE->MUL->DONE, with valid=1 in the cycle after E1.
REQ-013 SHALL compute MULT as the 64-bit signed product and MULTU as the 64-bit zero-extended product.
REQ-014 SHALL, for op=DIV/DIVU, go IDLE->DIV, run 32 restoring iterations on operand magnitudes using a 5-bit counter, then enter DONE, with valid=1 in the cycle after E33.
REQ-015 SHALL apply the DIV sign fixup in the last iteration cycle: quotient negated if sign(a)^sign(b); remainder takes sign(a); DIVU has no fixup.
REQ-016 SHALL, for divide by zero, return lo=32'hFFFFFFFF and hi=a, skipping the fixup.
REQ-017 SHALL drive stall = (state==IDLE & start & ~flush) | state==MUL | state==DIV, and stall=0 in DONE.
REQ-018 SHALL assert valid only in DONE, then return DONE->IDLE unconditionally; start seen in DONE SHALL NOT retrigger.
REQ-019 SHALL allow back-to-back operations: start=1 in the IDLE cycle after DONE begins a new operation.
REQ-020 SHALL, on flush=1 in any state, go to IDLE at the next edge with valid=0, leave hi/lo unchanged, and suppress any acceptance in that cycle.
REQ-021 SHALL hold hi/lo stable from DONE until the next valid; operand changes after E0 SHALL have no effect.

Reset
REQ-022 SHALL, on rst=0 at any time including mid-operation, immediately force state=IDLE, counter=0, hi=lo=0, valid=0 and stall=0.
REQ-023 SHALL take no new operation on the first edge after rst deasserts unless start=1.

Configuration
REQ-024 SHALL provide macro MULDIV_DIV_ZERO_FAST_EN: when defined, a divide with b==0 goes IDLE->DIV->DONE, with valid in the cycle after E1 and the REQ-016 result; when undefined, it takes the full 34-cycle path with the same result.

Structure
REQ-025 SHALL place the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the FSM state encodings and the constant DIV_ITERS=32 in the shared defines package.
REQ-026 SHALL implement the iterative restoring-divide datapath (magnitude shift/subtract, counter, fixup) as sub-module div_iter; the FSM, multiplier and result mux stay in muldiv_ctrl.

Verification
REQ-027 Bench: MULT a=32'hFFFFFFFE (-2), b=3 -> valid 2 cycles after start; hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; stall high exactly 2 cycles.
REQ-028 Bench: DIV a=-7 (32'hFFFFFFF9), b=2 -> valid in cycle 34; lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU 7/2 -> lo=3, hi=1.
REQ-029 Bench: DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5; valid in cycle 34 without the macro, cycle 2 with it.
REQ-030 Bench: flush at cycle 10 of a DIV -> IDLE next edge, no valid pulse, hi/lo unchanged; a MULT started next works normally.
REQ-031 Bench: rst=0 pulsed mid-DIV -> outputs zero immediately and state IDLE; start held through deassertion begins a clean operation.
REQ-032 Bench: start held continuously across DIVU 100/7 then MULTU 4x5 -> one valid each (lo=14 hi=2, then lo=20 hi=0), exactly one IDLE cycle between them.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and constants for the multiply/divide controller.
// Read by muldiv_ctrl and div_iter.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Iterative restoring divider: one prime cycle, then 32 shift/subtract steps.
// Sign fixup and divide-by-zero result are applied on the last step; macro MULDIV_DIV_ZERO_FAST_EN finishes b==0 in the prime cycle.
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [CNT_W-1:0] count;
    logic             primed;
    logic [31:0]      rem;
    logic [31:0]      quo;
    logic [31:0]      dvs;
    logic [32:0]      rem_shift;
    logic [32:0]      diff;
    logic [31:0]      rem_next;
    logic [31:0]      quo_next;
    logic             b_zero;
    logic             neg_q;
    logic             neg_r;

    assign b_zero = (b == 32'd0);
    assign neg_q  = sgn & (a[31] ^ b[31]);
    assign neg_r  = sgn & a[31];

    // Partial remainder stays below the divisor, so a 33-bit trial subtract suffices.
    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, dvs};
        rem_next  = rem_shift[31:0];
        quo_next  = {quo[30:0], 1'b0};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end
    end

`ifdef MULDIV_DIV_ZERO_FAST_EN
    assign last = step & (b_zero | (primed & (count == CNT_W'(DIV_ITERS - 1))));
`else
    assign last = step & primed & (count == CNT_W'(DIV_ITERS - 1));
`endif

    always_comb begin
        quotient  = neg_q ? -quo_next : quo_next;
        remainder = neg_r ? -rem_next : rem_next;
        if (b_zero) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = a;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            primed <= 1'b0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
        end else if (load) begin
            count  <= '0;
            primed <= 1'b0;
        end else if (step) begin
            if (!primed) begin
                rem    <= '0;
                quo    <= (sgn && a[31]) ? -a : a;
                dvs    <= (sgn && b[31]) ? -b : b;
                primed <= 1'b1;
            end else begin
                rem   <= rem_next;
                quo   <= quo_next;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: FSM, single-cycle multiplier and result registers.
// Divide datapath lives in div_iter; optional macro MULDIV_DIV_ZERO_FAST_EN shortens divide-by-zero.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state;
    state_e      state_next;
    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        accept;
    logic [63:0] product;
    logic        div_last;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign accept = (state == IDLE) & start & ~flush;
    // Stall is gated by reset so a held start cannot freeze the pipe while in reset.
    assign stall  = rst & (accept | (state == MUL) | (state == DIV));
    assign valid  = (state == DONE);

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = op_is_div(md_op_e'(op)) ? DIV : MUL;
                MUL:  state_next = DONE;
                DIV:  if (div_last) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= MD_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= md_op_e'(op);
            a_q  <= a;
            b_q  <= b;
        end
    end

    // The low 64 bits of a 64x64 product are exact for both extension modes.
    always_comb begin
        if (op_is_signed(op_q)) begin
            product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end else begin
            product = {32'd0, a_q} * {32'd0, b_q};
        end
    end

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state == DIV),
        .a         (a_q),
        .b         (b_q),
        .sgn       (op_is_signed(op_q)),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush) begin
            if (state == MUL) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end else if (div_last) begin
                hi <= div_rem;
                lo <= div_quo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed operations, latency, stall, flush and reset.
// Expected results are queued at issue and popped when valid pulses.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

`ifdef MULDIV_DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 34;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;

    res_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .valid (valid),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
        sb.push_back('{hi: eh, lo: el});
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Called in cycle 0 (just after the edge before E0); returns just after the edge ending DONE.
    task automatic wait_result(input string tag, input int exp_lat, input bit keep);
        int   lat    = -1;
        int   stalls = 0;
        res_t e      = '0;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                a  = $urandom;
                b  = $urandom;
                op = 2'($urandom);
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, {hi, lo});
        end else begin
            e = sb.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e.hi));
            check({tag, " lo"}, 64'(lo), 64'(e.lo));
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            start = 1'b0;
            @(negedge clk);
            check({tag, " valid single pulse"}, 64'(valid), 64'd0);
            check({tag, " result held"}, {hi, lo}, {e.hi, e.lo});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int pulses;
        rst   = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        op    = MD_MULT;
        a     = 32'd0;
        b     = 32'd0;

        // Reset state, with start held to show stall is suppressed in reset.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("post-reset idle stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset idle valid", 64'(valid), 64'd0);
        @(posedge clk);
        #1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_result("mult -2*3", 2, 1'b0);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_result("div -7/2", 34, 1'b0);
        issue(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        wait_result("divu 7/2", 34, 1'b0);
        issue(MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        wait_result("divu 5/0", DZ_LAT, 1'b0);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_result("div -7/0", DZ_LAT, 1'b0);
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        wait_result("div 7/-2", 34, 1'b0);
        issue(MD_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2);
        wait_result("div -8/-3", 34, 1'b0);
        issue(MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
        wait_result("divu max/1", 34, 1'b0);
        issue(MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
        wait_result("mult min*min", 2, 1'b0);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_result("multu max*max", 2, 1'b0);

        // Flush in cycle 10 of a divide: no pulse, previous result kept.
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush idle stall", 64'(stall), 64'd0);
        check("flush hi/lo kept", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("flush no valid", 64'(pulses), 64'd0);
        @(posedge clk);
        #1;

        // Flush in IDLE suppresses acceptance.
        start = 1'b1;
        flush = 1'b1;
        op    = MD_MULT;
        @(negedge clk);
        check("flush idle no accept stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush idle stays idle", 64'(stall), 64'd0);
        @(posedge clk);
        #1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_result("mult after flush", 2, 1'b0);

        // Reset mid-divide, then start held through deassertion.
        start = 1'b1;
        op    = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid reset hi/lo", {hi, lo}, 64'd0);
        check("mid reset valid", 64'(valid), 64'd0);
        check("mid reset stall", 64'(stall), 64'd0);
        issue(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_result("divu after reset", 34, 1'b0);

        // Start held continuously across two operations.
        issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_result("b2b divu 100/7", 34, 1'b1);
        issue(MD_MULTU, 32'd4, 32'd5, 32'd0, 32'd20);
        wait_result("b2b multu 4*5", 2, 1'b0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
